// File: rtl/seq_mult_param.sv
// Parametrised shift-and-add unsigned multiplier with start/busy/done handshake.
// Optional macro SEQ_MULT_SKIP_ZERO_EN bypasses the ADD step for zero multiplier bits.
module seq_mult_param #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mr;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic               first_add;
  logic               next_add;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mr[0]}}};

`ifdef SEQ_MULT_SKIP_ZERO_EN
  // mr[1] is the bit that becomes the LSB once the current SHIFT completes.
  assign first_add = multiplier[0];
  assign next_add  = mr[1];
`else
  assign first_add = 1'b1;
  assign next_add  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mr      <= '0;
      mcand   <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= multiplicand;
            mr    <= multiplier;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= first_add ? ADD : SHIFT;
          end
        end
        ADD: begin
          acc[2*WIDTH:WIDTH] <= sum;
          state              <= SHIFT;
        end
        SHIFT: begin
          acc <= acc >> 1;
          mr  <= mr >> 1;
          if (count == LAST) begin
            // The carry is always zero after the final shift, so the product is acc[2W:1].
            product <= acc[2*WIDTH:1];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            count <= count + CW'(1);
            state <= next_add ? ADD : SHIFT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: a 4-bit and an 8-bit instance checked
// against a latency/product model every cycle, plus directed literal expectations.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  mr4, md4;
  logic [7:0]  mr8, md8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .multiplier(mr4), .multiplicand(md4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .multiplier(mr8), .multiplicand(md8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: an accepted request yields busy for L cycles, then done for one cycle with md*mr.
  function automatic int latency(input int w, input logic [7:0] mr);
`ifdef SEQ_MULT_SKIP_ZERO_EN
    return w + $countones(mr);
`else
    return 2 * w;
`endif
  endfunction

  logic        in_start[2];
  logic [7:0]  in_md[2];
  logic [7:0]  in_mr[2];
  logic        m_busy[2];
  logic        m_done[2];
  logic [15:0] m_prod[2];
  logic [15:0] m_pend[2];
  int          m_rem[2];

  assign in_start[0] = start4;
  assign in_start[1] = start8;
  assign in_md[0]    = {4'b0, md4};
  assign in_md[1]    = md8;
  assign in_mr[0]    = {4'b0, mr4};
  assign in_mr[1]    = mr8;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_prod[i] <= '0;
        m_pend[i] <= '0;
        m_rem[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_done[i]) begin
          m_done[i] <= 1'b0;
        end else if (m_busy[i]) begin
          if (m_rem[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_prod[i] <= m_pend[i];
          end
          m_rem[i] <= m_rem[i] - 1;
        end else if (in_start[i]) begin
          m_busy[i] <= 1'b1;
          m_pend[i] <= 16'(in_md[i]) * 16'(in_mr[i]);
          m_rem[i]  <= latency((i == 0) ? 4 : 8, in_mr[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy4", 64'(busy4), 64'(m_busy[0]));
    checkOutput("done4", 64'(done4), 64'(m_done[0]));
    checkOutput("prod4", 64'(prod4), 64'(m_prod[0][7:0]));
    checkOutput("busy8", 64'(busy8), 64'(m_busy[1]));
    checkOutput("done8", 64'(done8), 64'(m_done[1]));
    checkOutput("prod8", 64'(prod8), 64'(m_prod[1]));
  end

  // Start is presented one cycle, accepted on the following edge (edge 0), then dropped.
  task automatic applyStimulus(input int i, input logic [7:0] md, input logic [7:0] mr);
    @(posedge clk);
    #2;
    if (i == 0) begin
      md4 = md[3:0]; mr4 = mr[3:0]; start4 = 1'b1;
    end else begin
      md8 = md; mr8 = mr; start8 = 1'b1;
    end
    @(posedge clk);
    #2;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Returns the edge index after which done was first seen and the busy cycle count.
  task automatic waitDone(input int i, input int pulseAt, output int edgeN, output int busyN);
    int k = 0;
    edgeN = -1;
    busyN = 0;
    while (k < 100) begin
      @(negedge clk);
      if (pulseAt >= 0 && k == pulseAt) start8 = 1'b1;
      if (pulseAt >= 0 && k == pulseAt + 1) start8 = 1'b0;
      if (((i == 0) ? done4 : done8) === 1'b1) begin
        edgeN = k;
        break;
      end
      if (((i == 0) ? busy4 : busy8) === 1'b1) busyN++;
      k++;
    end
    if (edgeN < 0) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int n, nb, k, pulses;
    rst = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    md4 = '0; mr4 = '0; md8 = '0; mr8 = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_prod4", 64'(prod4), 64'(0));
      checkOutput("idle_busy4", 64'(busy4), 64'(0));
    end

    applyStimulus(0, 8'd13, 8'd11);
    waitDone(0, -1, n, nb);
`ifdef SEQ_MULT_SKIP_ZERO_EN
    checkOutput("13x11_done_edge", 64'(n), 64'(7));
    checkOutput("13x11_busy_cycles", 64'(nb), 64'(7));
`else
    checkOutput("13x11_done_edge", 64'(n), 64'(8));
    checkOutput("13x11_busy_cycles", 64'(nb), 64'(8));
`endif
    checkOutput("13x11_product", 64'(prod4), 64'(143));
    @(negedge clk);
    checkOutput("13x11_done_width", 64'(done4), 64'(0));

    applyStimulus(1, 8'd255, 8'd255);
    waitDone(1, 5, n, nb);
    checkOutput("255x255_done_edge", 64'(n), 64'(16));
    checkOutput("255x255_product", 64'(prod8), 64'(65025));
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    checkOutput("255x255_extra_done", 64'(pulses), 64'(0));

    applyStimulus(0, 8'd7, 8'd6);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy4", 64'(busy4), 64'(0));
    checkOutput("rst_done4", 64'(done4), 64'(0));
    checkOutput("rst_prod4", 64'(prod4), 64'(0));
    checkOutput("rst_prod8", 64'(prod8), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4 === 1'b1) pulses++;
    end
    checkOutput("rst_no_done", 64'(pulses), 64'(0));
    applyStimulus(0, 8'd7, 8'd6);
    waitDone(0, -1, n, nb);
    checkOutput("7x6_product", 64'(prod4), 64'(42));

    @(posedge clk);
    #2;
    md4 = 4'd15; mr4 = 4'd15; start4 = 1'b1;
    @(posedge clk);
    #2;
    md4 = 4'd0; mr4 = 4'd9;
    waitDone(0, -1, n, nb);
    checkOutput("15x15_done_edge", 64'(n), 64'(8));
    checkOutput("15x15_product", 64'(prod4), 64'(225));
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) start4 = 1'b0;
      if (done4 === 1'b1) break;
      checkOutput("hold_225", 64'(prod4), 64'(225));
    end
`ifdef SEQ_MULT_SKIP_ZERO_EN
    checkOutput("b2b_done_gap", 64'(k), 64'(8));
`else
    checkOutput("b2b_done_gap", 64'(k), 64'(10));
`endif
    checkOutput("0x9_product", 64'(prod4), 64'(0));

    applyStimulus(0, 8'd9, 8'd8);
    waitDone(0, -1, n, nb);
`ifdef SEQ_MULT_SKIP_ZERO_EN
    checkOutput("9x8_done_edge", 64'(n), 64'(5));
`else
    checkOutput("9x8_done_edge", 64'(n), 64'(8));
`endif
    checkOutput("9x8_product", 64'(prod4), 64'(72));

    applyStimulus(0, 8'd9, 8'd15);
    waitDone(0, -1, n, nb);
    checkOutput("9x15_done_edge", 64'(n), 64'(8));
    checkOutput("9x15_product", 64'(prod4), 64'(135));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
